// File: rtl/binary_divider_3bit_seq.sv
// binary_divider_3bit_seq: sequential restoring divider, 2N-bit dividend / N-bit divisor.
// Latency: start edge -> 2N RUN cycles -> DONE; done pulses in cycle 2N+1 after the start edge.
// Backpressure: none; start is sampled only in IDLE, ignored while busy (no queuing).
// Optional: define DIV_ZERO_DETECT_EN to add div_by_zero and short-circuit B=0 straight to DONE.
module binary_divider_3bit_seq #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   A,
    input  logic [N-1:0]     B,
    output logic [2*N-1:0]   Q,
    output logic [N-1:0]     R,
    output logic             busy,
    output logic             done
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int W2 = 2 * N;
    localparam int CW = $clog2(W2 + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W2-1:0]   a_q;      // dividend, shifted left one bit per RUN cycle
    logic [N-1:0]    b_q;      // latched divisor
    logic [N:0]      rem_q;    // partial remainder
    logic [W2-1:0]   quo_q;    // quotient bits collected MSB first
    logic [CW-1:0]   cnt_q;    // quotient bits still to produce
    logic [W2-1:0]   q_q;
    logic [N-1:0]    r_q;
    logic            busy_q;
    logic            done_q;
`ifdef DIV_ZERO_DETECT_EN
    logic            dz_q;
`endif

    logic [N:0]      rem_sh;
    logic            rem_ge;
    logic [N:0]      rem_d;
    logic [W2-1:0]   quo_d;

    // One restoring step: bring in the next dividend bit, subtract when the divisor fits.
    // With a zero divisor every step "fits", giving all-ones quotient and the low dividend bits as remainder.
    always_comb begin
        rem_sh = (rem_q << 1) | {{N{1'b0}}, a_q[W2-1]};
        rem_ge = (rem_sh >= {1'b0, b_q});
        rem_d  = rem_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
        quo_d  = (quo_q << 1) | {{(W2-1){1'b0}}, rem_ge};
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        a_q    <= A;
                        b_q    <= B;
                        rem_q  <= '0;
                        quo_q  <= '0;
                        cnt_q  <= CNT_INIT;
                        busy_q <= 1'b1;
                        state_q <= RUN;
`ifdef DIV_ZERO_DETECT_EN
                        // Zero divisor: skip the iterations and report immediately.
                        if (B == '0) begin
                            cnt_q   <= '0;
                            q_q     <= '0;
                            r_q     <= '0;
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                            state_q <= DONE;
                        end
`endif
                    end
                end
                RUN: begin
                    a_q   <= a_q << 1;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        q_q     <= quo_d;
                        r_q     <= rem_d[N-1:0];
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                    dz_q    <= 1'b0;
`endif
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = dz_q;
`endif

endmodule

// File: tb/tb_binary_divider_3bit_seq.sv
// Testbench for binary_divider_3bit_seq: directed and random divisions checked by a scoreboard.
// The driver pushes expected results computed with plain / and %; a monitor pops on every done.
// Latency, busy, reset-abort, ignored-start and back-to-back behaviour are checked by the driver.
module tb_binary_divider_3bit_seq;

    localparam int N = 3;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2*N-1:0] A;
    logic [N-1:0]   B;
    logic [2*N-1:0] Q;
    logic [N-1:0]   R;
    logic           busy;
    logic           done;
`ifdef DIV_ZERO_DETECT_EN
    logic           div_by_zero;
    localparam bit  DZ = 1'b1;
`else
    localparam bit  DZ = 1'b0;
`endif

    typedef struct {
        int q;
        int r;
        int dz;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    binary_divider_3bit_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done)
`ifdef DIV_ZERO_DETECT_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer division; zero divisor gives all ones / low dividend bits, or zeros when detected.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q  = DZ ? 0 : (1 << (2 * N)) - 1;
            e.r  = DZ ? 0 : a % (1 << N);
            e.dz = DZ ? 1 : 0;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 0;
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending result at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("Q", int'(Q), e.q);
                check("R", int'(R), e.r);
`ifdef DIV_ZERO_DETECT_EN
                check("div_by_zero", int'(div_by_zero), e.dz);
`endif
            end
        end
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (k == 40) check("idle_timeout", 1, 0);
    endtask

    // Issue one division and measure cycles from the start edge to done.
    task automatic run_div(input int a, input int b, input bit scramble);
        int lat;
        int exp_lat;
        exp_lat = (DZ && b == 0) ? 1 : 2 * N + 1;
        wait_idle();
        @(posedge clk); #1;
        A = (2*N)'(a); B = N'(b); start = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) begin
            A = (2*N)'($urandom); B = N'($urandom);
        end
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_cycle1", int'(busy), 1);
            if (done) begin
                lat = c;
                check("busy_at_done", int'(busy), 1);
                break;
            end
        end
        check("latency", lat, exp_lat);
        @(negedge clk);
        check("busy_after", int'(busy), 0);
        check("done_after", int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcyc[$];
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        #1;
        check("reset_Q", int'(Q), 0);
        check("reset_R", int'(R), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_div(49, 7, 1'b1);
        run_div(45, 4, 1'b1);
        run_div(63, 1, 1'b1);
        run_div(5, 7, 1'b1);
        run_div(12, 0, 1'b1);
        run_div(0, 5, 1'b0);
        run_div(63, 0, 1'b0);

        // A second start during RUN is ignored: only one result expected.
        wait_idle();
        @(posedge clk); #1;
        A = 6'd15; B = 3'd3; start = 1'b1;
        sb.push_back(model(15, 3));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        A = 6'd6; B = 3'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("ignored_start_drained", sb.size(), 0);

        // Reset in the third RUN cycle aborts without a done pulse.
        wait_idle();
        @(posedge clk); #1;
        A = 6'd20; B = 3'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_Q", int'(Q), 0);
        check("abort_R", int'(R), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_div(6, 2, 1'b0);

        // start held high: back-to-back divisions every 2N+2 cycles.
        wait_idle();
        @(posedge clk); #1;
        A = 6'd49; B = 3'd7; start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(model(49, 7));
        @(posedge clk); #1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 20) start = 1'b0;
            if (done) dcyc.push_back(c);
        end
        check("b2b_count", dcyc.size(), 3);
        if (dcyc.size() == 3) begin
            check("b2b_first", dcyc[0], 2 * N + 1);
            check("b2b_period1", dcyc[1] - dcyc[0], 2 * N + 2);
            check("b2b_period2", dcyc[2] - dcyc[1], 2 * N + 2);
        end

        // Random divisions, inputs scrambled after the start edge.
        for (int i = 0; i < 40; i++) begin
            run_div($urandom_range(0, 63), $urandom_range(0, 7), 1'b1);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/binary_divider_3bit_seq.md
BINARY_DIVIDER_3BIT_SEQ -- requirements
Module: binary_divider_3bit_seq

Interface
REQ-001 Parameter N, default 3, divisor width; dividend and quotient are 2N bits (the width of an N x N product).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 A  input  2N  dividend, unsigned.
REQ-006 B  input  N  divisor, unsigned.
REQ-007 Q  output  2N  quotient, registered.
REQ-008 R  output  N  remainder, registered.
REQ-009 busy  output  1  high while a division is in progress (RUN or DONE).
REQ-010 done  output  1  one-cycle pulse; Q/R valid from this cycle onward.

Function
REQ-011 FSM states: IDLE, RUN, DONE; transitions: IDLE->RUN on start=1; RUN->DONE when bit counter reaches 0; DONE->IDLE unconditionally.
REQ-012 On the start edge: latch A and B into internal registers, clear the partial remainder, load the counter with 2N; later changes on A/B do not affect the running division.
REQ-013 RUN: restoring algorithm, one quotient bit per cycle, MSB first; shift the next dividend bit into the partial remainder (N+1 bits wide); if it is >= divisor, subtract and set the quotient bit to 1, else set it to 0.
REQ-014 Latency: 2N RUN cycles, then DONE; done=1 exactly during the (2N+1)th cycle after the start edge (7th cycle for N=3).
REQ-015 Q and R update only on entry to DONE and hold until the next completion.
REQ-016 start is ignored in RUN and DONE; no queuing.
REQ-017 start is held high continuously: a new division begins on the first IDLE cycle after DONE (back-to-back period 2N+2 cycles).
REQ-018 Results satisfy A = Q*B + R with R < B for B != 0.
REQ-019 B = 0 (macro absent): the block runs the full 2N cycles and produces Q = all ones, R = A[N-1:0].
REQ-020 busy=1 in RUN and DONE, 0 in IDLE; done=0 outside DONE.

Reset
REQ-021 rst=1 forces state IDLE, Q=0, R=0, busy=0, done=0, counter=0, internal registers cleared, immediately and independent of clk.
REQ-022 Reset mid-RUN aborts the division; no done pulse follows; the next start after rst deasserts runs normally.

Configuration
REQ-023 Macro DIV_ZERO_DETECT_EN, when defined: adds output port div_by_zero (1 bit, reset 0).
REQ-024 With DIV_ZERO_DETECT_EN, B=0 at the start edge goes IDLE->DONE directly, skipping RUN; done and div_by_zero pulse together in the cycle after start, with Q=0 and R=0.
REQ-025 With DIV_ZERO_DETECT_EN, div_by_zero=0 for every nonzero-divisor completion.
REQ-026 Without DIV_ZERO_DETECT_EN: no div_by_zero port exists and REQ-019 applies.

Verification
REQ-027 A=49, B=7, start pulse -> done in 7th cycle, Q=7, R=0, busy high for cycles 1-7.
REQ-028 A=45, B=4 -> Q=11, R=1; A=63, B=1 -> Q=63, R=0; A=5, B=7 -> Q=0, R=5.
REQ-029 A=15, B=3 started, then A=6, B=2 with start pulsed during RUN -> only one done, Q=5, R=0; the second request is ignored.
REQ-030 rst asserted in 3rd RUN cycle -> outputs 0 at once, no done; then A=6, B=2 -> Q=3, R=0.
REQ-031 A=12, B=0: without macro -> done in 7th cycle, Q=63, R=4; with DIV_ZERO_DETECT_EN -> done and div_by_zero in cycle 1, Q=0, R=0.
REQ-032 start held high, A=49, B=7 -> done pulses every 8 cycles, each with Q=7, R=0.
